// File: rtl/neuron_mac_sequencer_if.sv
// Bus between the layer sequencer, its input buffer / weight ROM and the next stage.
// The sequencer is the master: it issues addresses and presents results.
interface neuron_mac_sequencer_if #(
    parameter int N_NEURONS = 4,
    parameter int IDX_W     = 8,
    parameter int IN_W      = 16,
    parameter int W_W       = 35,
    parameter int OUT_W     = 16
) ();
    logic                       start;
    logic                       busy;
    logic                       x_rd_en;
    logic [IDX_W-1:0]           x_addr;
    logic [IN_W-1:0]            x_data;
    logic [IDX_W-1:0]           w_idx;
    logic [N_NEURONS*W_W-1:0]   weights_in;
    logic                       out_valid;
    logic                       out_ready;
    logic [N_NEURONS*OUT_W-1:0] results;

    modport master (
        input  start, x_data, weights_in, out_ready,
        output busy, x_rd_en, x_addr, w_idx, out_valid, results
    );

    modport slave (
        output start, x_data, weights_in, out_ready,
        input  busy, x_rd_en, x_addr, w_idx, out_valid, results
    );
endinterface

// File: rtl/neuron_mac_sequencer.sv
// Fully connected layer sequencer: streams N_INPUTS samples against N_NEURONS weight
// columns, then presents scaled, saturated sums behind a valid/ready handshake.
module neuron_mac_sequencer #(
    parameter int N_INPUTS   = 144,
    parameter int N_NEURONS  = 4,
    parameter int IDX_W      = 8,
    parameter int IN_W       = 16,
    parameter int W_W        = 35,
    parameter int ACC_W      = 64,
    parameter int FRAC_SHIFT = 32,
    parameter int OUT_W      = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    neuron_mac_sequencer_if.master bus
);
    localparam int P_W = IN_W + W_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUTS - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                     r_state;
    state_t                     w_state_next;
    logic [IDX_W-1:0]           r_idx;
    logic                       r_rd_en;
    logic                       r_out_valid;
    logic                       r_w_vld;
    logic                       r_p_vld;
    logic signed [W_W-1:0]      r_w_reg [N_NEURONS];
    logic signed [P_W-1:0]      r_prod  [N_NEURONS];
    logic signed [ACC_W-1:0]    r_acc   [N_NEURONS];
    logic [N_NEURONS*OUT_W-1:0] r_results;
    logic [N_NEURONS*OUT_W-1:0] w_sat;
    logic signed [ACC_W-1:0]    w_scaled [N_NEURONS];
    logic signed [P_W-1:0]      w_x_ext;

    assign w_x_ext = {{W_W{bus.x_data[IN_W-1]}}, bus.x_data};

    // DRAIN ends once both pipeline stages are empty, i.e. the last product is in acc.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (bus.start)         w_state_next = ISSUE;
            ISSUE:   if (r_idx == LAST_IDX) w_state_next = DRAIN;
            DRAIN:   if (!r_w_vld && !r_p_vld) w_state_next = DONE;
            DONE:    if (bus.out_ready)     w_state_next = IDLE;
            default:                        w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_sat = '0;
        for (int unsigned n = 0; n < N_NEURONS; n++) begin
            w_scaled[n] = r_acc[n] >>> FRAC_SHIFT;
            if (w_scaled[n] > SAT_MAX)
                w_sat[n*OUT_W +: OUT_W] = SAT_MAX[OUT_W-1:0];
            else if (w_scaled[n] < SAT_MIN)
                w_sat[n*OUT_W +: OUT_W] = SAT_MIN[OUT_W-1:0];
            else
                w_sat[n*OUT_W +: OUT_W] = w_scaled[n][OUT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_rd_en     <= 1'b0;
            r_out_valid <= 1'b0;
            r_w_vld     <= 1'b0;
            r_p_vld     <= 1'b0;
            r_results   <= '0;
            for (int unsigned n = 0; n < N_NEURONS; n++) begin
                r_w_reg[n] <= '0;
                r_prod[n]  <= '0;
                r_acc[n]   <= '0;
            end
        end else begin
            r_state     <= w_state_next;
            r_rd_en     <= (w_state_next == ISSUE);
            r_out_valid <= (w_state_next == DONE);
            r_w_vld     <= (r_state == ISSUE);
            r_p_vld     <= r_w_vld;

            if (w_state_next == IDLE)
                r_idx <= '0;
            else if (r_state == ISSUE && w_state_next == ISSUE)
                r_idx <= r_idx + IDX_W'(1);

            if (r_state == DRAIN && w_state_next == DONE)
                r_results <= w_sat;

            for (int unsigned n = 0; n < N_NEURONS; n++) begin
                if (r_state == ISSUE)
                    r_w_reg[n] <= bus.weights_in[n*W_W +: W_W];
                if (r_w_vld)
                    r_prod[n] <= $signed(w_x_ext * $signed({{IN_W{r_w_reg[n][W_W-1]}}, r_w_reg[n]}));
                if (r_state == IDLE && bus.start)
                    r_acc[n] <= '0;
                else if (r_p_vld)
                    r_acc[n] <= r_acc[n] + {{(ACC_W-P_W){r_prod[n][P_W-1]}}, r_prod[n]};
            end
        end
    end

    assign bus.busy      = (r_state != IDLE);
    assign bus.x_rd_en   = r_rd_en;
    assign bus.x_addr    = r_idx;
    assign bus.w_idx     = r_idx;
    assign bus.out_valid = r_out_valid;
    assign bus.results   = r_results;
endmodule

// File: tb/tb_neuron_mac_sequencer.sv
// Bench for neuron_mac_sequencer: directed layer passes plus randomized vectors
// checked against a plain-arithmetic dot-product model.
module tb_neuron_mac_sequencer;
    localparam int N_INPUTS   = 144;
    localparam int N_NEURONS  = 4;
    localparam int IDX_W      = 8;
    localparam int IN_W       = 16;
    localparam int W_W        = 35;
    localparam int ACC_W      = 64;
    localparam int FRAC_SHIFT = 32;
    localparam int OUT_W      = 16;
    localparam int LATENCY    = N_INPUTS + 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    neuron_mac_sequencer_if #(
        .N_NEURONS(N_NEURONS), .IDX_W(IDX_W), .IN_W(IN_W), .W_W(W_W), .OUT_W(OUT_W)
    ) bus ();

    neuron_mac_sequencer #(
        .N_INPUTS(N_INPUTS), .N_NEURONS(N_NEURONS), .IDX_W(IDX_W), .IN_W(IN_W),
        .W_W(W_W), .ACC_W(ACC_W), .FRAC_SHIFT(FRAC_SHIFT), .OUT_W(OUT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    logic [IN_W-1:0] x_mem [N_INPUTS];
    logic [W_W-1:0]  w_mem [N_INPUTS][N_NEURONS];
    longint          exp_res [N_NEURONS];
    int              n_tests = 0;
    int              n_fail  = 0;
    int              cyc     = 0;

    // Input buffer: one-cycle read latency. Weight ROM: combinational.
    always @(posedge clk)
        if (bus.x_rd_en) bus.x_data <= x_mem[int'(bus.x_addr)];

    always_comb begin
        bus.weights_in = '0;
        for (int n = 0; n < N_NEURONS; n++)
            bus.weights_in[n*W_W +: W_W] = w_mem[int'(bus.w_idx)][n];
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model_expected();
        longint acc;
        for (int n = 0; n < N_NEURONS; n++) begin
            acc = 0;
            for (int k = 0; k < N_INPUTS; k++)
                acc += longint'($signed(x_mem[k])) * longint'($signed(w_mem[k][n]));
            acc = acc >>> FRAC_SHIFT;
            if (acc > 32767) acc = 32767;
            if (acc < -32768) acc = -32768;
            exp_res[n] = acc;
        end
    endfunction

    task automatic load_unity();
        for (int k = 0; k < N_INPUTS; k++) begin
            x_mem[k] = IN_W'(1);
            for (int n = 0; n < N_NEURONS; n++) w_mem[k][n] = 35'h100000000;
        end
        for (int n = 0; n < N_NEURONS; n++) exp_res[n] = 144;
    endtask

    task automatic load_random();
        logic signed [W_W-1:0] t;
        for (int k = 0; k < N_INPUTS; k++) begin
            x_mem[k] = IN_W'($urandom());
            for (int n = 0; n < N_NEURONS; n++) begin
                t = W_W'({$urandom(), $urandom()});
                w_mem[k][n] = t >>> $urandom_range(0, 12);
            end
        end
        model_expected();
    endtask

    task automatic run_pass(input string tag);
        int busy_bad;
        int addr_bad;
        busy_bad = 0;
        addr_bad = 0;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 1;
        while (bus.out_valid !== 1'b1 && cyc < LATENCY + 20) begin
            if (bus.busy !== 1'b1) busy_bad++;
            if (cyc <= N_INPUTS) begin
                if (bus.x_rd_en !== 1'b1 || int'(bus.x_addr) != cyc - 1 || int'(bus.w_idx) != cyc - 1)
                    addr_bad++;
            end else if (bus.x_rd_en !== 1'b0 || int'(bus.x_addr) != N_INPUTS - 1 ||
                         int'(bus.w_idx) != N_INPUTS - 1) begin
                addr_bad++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, " latency"}, cyc, LATENCY);
        check({tag, " busy_during_pass"}, busy_bad, 0);
        check({tag, " addr_sequence"}, addr_bad, 0);
        check({tag, " busy_in_done"}, bus.busy, 1);
        for (int n = 0; n < N_NEURONS; n++)
            check($sformatf("%s result[%0d]", tag, n),
                  longint'($signed(bus.results[n*OUT_W +: OUT_W])), exp_res[n]);
    endtask

    task automatic finish_handshake(input string tag, input int hold);
        logic [N_NEURONS*OUT_W-1:0] snap;
        int bad;
        snap = bus.results;
        bad  = 0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            bus.start = (i % 3 == 1);
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b1 || bus.results !== snap || bus.busy !== 1'b1) bad++;
        end
        bus.start = 1'b0;
        if (hold > 0) check({tag, " hold_stable"}, bad, 0);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({tag, " valid_after_accept"}, bus.out_valid, 0);
        check({tag, " idle_after_accept"}, bus.busy, 0);
        check({tag, " results_held"}, longint'(bus.results), longint'(snap));
        @(posedge clk); #1;
        check({tag, " no_queued_start"}, bus.busy, 0);
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.out_ready = 1'b0;
        load_unity();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", bus.busy, 0);
        check("reset x_rd_en", bus.x_rd_en, 0);
        check("reset out_valid", bus.out_valid, 0);
        check("reset x_addr", bus.x_addr, 0);
        check("reset w_idx", bus.w_idx, 0);
        check("reset results", longint'(bus.results), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        load_unity();
        run_pass("unity");
        finish_handshake("unity", 0);

        for (int k = 0; k < N_INPUTS; k++) begin
            x_mem[k] = IN_W'(k);
            for (int n = 0; n < N_NEURONS; n++) w_mem[k][n] = '0;
            w_mem[k][2] = (k % 2 == 0) ? 35'h080000000 : 35'h780000000;
        end
        exp_res[0] = 0; exp_res[1] = 0; exp_res[2] = -36; exp_res[3] = 0;
        run_pass("signmix");
        finish_handshake("signmix", 1);

        for (int k = 0; k < N_INPUTS; k++) begin
            x_mem[k] = IN_W'(32767);
            w_mem[k][0] = 35'h3FFFFFFFF;
            w_mem[k][1] = 35'h400000000;
            w_mem[k][2] = '0;
            w_mem[k][3] = '0;
        end
        exp_res[0] = 32767; exp_res[1] = -32768; exp_res[2] = 0; exp_res[3] = 0;
        run_pass("saturate");
        finish_handshake("saturate", 2);

        for (int r = 0; r < 3; r++) begin
            load_random();
            run_pass($sformatf("random%0d", r));
            finish_handshake($sformatf("random%0d", r), int'($urandom_range(0, 3)));
        end

        load_random();
        run_pass("backpressure");
        finish_handshake("backpressure", 10);

        load_random();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 1;
        while (cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midreset busy", bus.busy, 0);
        check("midreset x_rd_en", bus.x_rd_en, 0);
        check("midreset out_valid", bus.out_valid, 0);
        check("midreset x_addr", bus.x_addr, 0);
        check("midreset w_idx", bus.w_idx, 0);
        check("midreset results", longint'(bus.results), 0);
        load_unity();
        run_pass("after_reset");
        finish_handshake("after_reset", 0);

        load_random();
        run_pass("b2b_first");
        bus.out_ready = 1'b1;
        bus.start     = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.start     = 1'b0;
        check("b2b valid_after_accept", bus.out_valid, 0);
        check("b2b start_ignored", bus.busy, 0);
        load_random();
        run_pass("b2b_second");
        finish_handshake("b2b_second", 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
